// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store bus controller:
//   lsu_state_e          - controller FSM states
//   lsu_size_e           - access size encodings (SZ_B, SZ_H, SZ_W; 2'b11 acts as word)
//   LSU_MAX_WAIT_DEFAULT - default bus wait budget before a timeout
//   is_misaligned()      - alignment rule used by the optional misalign trap
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADDR  = 2'b01,
        RDATA = 2'b10,
        DONE  = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B  = 2'b00,
        SZ_H  = 2'b01,
        SZ_W  = 2'b10,
        SZ_WX = 2'b11   // reserved encoding, behaves as a word access
    } lsu_size_e;

    localparam int unsigned LSU_MAX_WAIT_DEFAULT = 16;

    // Half needs addr[0]==0; word (either encoding) needs addr[1:0]==0.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl_if
// Word-oriented memory bus between the LSU controller and the memory side.
//   bus_valid/bus_ready  address-phase handshake
//   bus_we               write enable
//   bus_addr             word-aligned byte address
//   bus_wdata/bus_be     lane-replicated store data and byte enables
//   bus_rvalid/bus_rdata read data return
// Modports: master (controller), slave (memory).
// ---------------------------------------------------------------------------
interface lsu_bus_ctrl_if;

    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/lsu_lane.sv
// ---------------------------------------------------------------------------
// lsu_lane
// Purely combinational byte-lane steering.
//   Store side: st_size_i/st_addr_lo_i/st_wdata_i -> st_be_o, st_wdata_o
//               (data replicated across every lane it may land in)
//   Load side:  ld_size_i/ld_addr_lo_i/ld_rdata_i -> ld_rdata_o
//               (selected lane right-justified, zero-filled)
// Half accesses look at addr[1] only; word accesses ignore the low bits.
// ---------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_size_e   st_size_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  lsu_size_e   ld_size_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_rdata_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // assignment on any branch would infer a latch.
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SZ_B: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SZ_H: begin
                st_be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_rdata_o = ld_rdata_i;
        case (ld_size_i)
            SZ_B:    ld_rdata_o = {24'b0, 8'(ld_rdata_i >> {ld_addr_lo_i, 3'b000})};
            SZ_H:    ld_rdata_o = {16'b0, 16'(ld_rdata_i >> {ld_addr_lo_i[1], 4'b0000})};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
// Turns a held datapath load/store request into one bus transaction.
//   clk, rst         clock, asynchronous active-high reset
//   req_*_i          datapath request (held until the rsp_valid cycle)
//   stall_o          freezes PC / register write while the access is open
//   rsp_valid_o      one-cycle completion pulse
//   rsp_rdata_o      load data, zero-extended, held until the next load
//   rsp_err_o        timeout, pulses with rsp_valid_o
//   misalign_o       misaligned access, pulses with rsp_valid_o
//   bus              lsu_bus_ctrl_if.master
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses without touching the bus; otherwise low address bits are ignored
// and misalign_o stays 0.
// ---------------------------------------------------------------------------
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = LSU_MAX_WAIT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid_i,
    input  logic           req_we_i,
    input  logic [1:0]     req_size_i,
    input  logic [31:0]    req_addr_i,
    input  logic [31:0]    req_wdata_i,
    output logic           stall_o,
    output logic           rsp_valid_o,
    output logic [31:0]    rsp_rdata_o,
    output logic           rsp_err_o,
    output logic           misalign_o,
    lsu_bus_ctrl_if.master bus
);

    // One spare count so the counter can pass MAX_WAIT after a late handshake.
    localparam int unsigned       WAIT_W     = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    lsu_state_e        state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    lsu_size_e         size_q;
    logic [1:0]        addr_lo_q;
    logic              bus_valid_q;
    logic              bus_we_q;
    logic [31:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [3:0]        bus_be_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              misalign_q;
    logic [31:0]       rsp_rdata_q;

    lsu_size_e   req_size;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        misaligned;
    logic        timeout;

    assign req_size = lsu_size_e'(req_size_i);

    // Store lanes come straight from the request (captured on IDLE->ADDR);
    // load extraction uses the captured size/offset.
    lsu_lane u_lane (
        .st_size_i    (req_size),
        .st_addr_lo_i (req_addr_i[1:0]),
        .st_wdata_i   (req_wdata_i),
        .st_be_o      (lane_be),
        .st_wdata_o   (lane_wdata),
        .ld_size_i    (size_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_rdata_i   (bus.bus_rdata),
        .ld_rdata_o   (lane_rdata)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(req_size, req_addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // The cycle being counted is the one that reaches the limit.
    assign wait_d  = wait_q + WAIT_W'(1);
    assign timeout = (wait_d >= WAIT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            size_q      <= SZ_B;
            addr_lo_q   <= 2'b00;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values regardless of statement order.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (misaligned) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            misalign_q  <= 1'b1;
                        end else begin
                            state_q     <= ADDR;
                            wait_q      <= '0;
                            size_q      <= req_size;
                            addr_lo_q   <= req_addr_i[1:0];
                            bus_valid_q <= 1'b1;
                            bus_we_q    <= req_we_i;
                            bus_addr_q  <= {req_addr_i[31:2], 2'b00};
                            bus_wdata_q <= lane_wdata;
                            bus_be_q    <= lane_be;
                        end
                    end
                end
                ADDR: begin
                    wait_q <= wait_d;
                    // A handshake in the last budget cycle still wins.
                    if (bus.bus_ready) begin
                        bus_valid_q <= 1'b0;
                        if (bus_we_q) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                        end else if (bus.bus_rvalid) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= lane_rdata;
                        end else begin
                            state_q <= RDATA;
                        end
                    end else if (timeout) begin
                        bus_valid_q <= 1'b0;
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                RDATA: begin
                    wait_q <= wait_d;
                    if (bus.bus_rvalid) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= lane_rdata;
                    end else if (timeout) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Released in DONE so the datapath advances in the response cycle.
    assign stall_o       = req_valid_i && (state_q != DONE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign misalign_o    = misalign_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_ctrl
// Self-checking bench for lsu_bus_ctrl: reset values, a table of directed
// transactions, back-to-back requests, randomized transactions scored
// against a transaction-level model, and reset during a read.
// ---------------------------------------------------------------------------
module tb_lsu_bus_ctrl;

    localparam int MAX_WAIT = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        misalign;

    lsu_bus_ctrl_if bus_if ();

    lsu_bus_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .stall_o     (stall),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .misalign_o  (misalign),
        .bus         (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One transaction: request, bus behaviour, expected outcome.
    // r = ADDR cycles before bus_ready; d = RDATA cycles until rvalid (0 = with ready).
    // lat = cycle of the rsp_valid pulse counting the request cycle as 0;
    // addr_last = last cycle bus_valid is high.
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          r;
        int          d;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata_exp;
        logic        err;
        logic        mis;
        int          lat;
        int          addr_last;
    } txn_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic txn_t vec(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int r,
                                 input int d, input logic [3:0] be, input logic [31:0] baddr,
                                 input logic [31:0] bwdata, input logic [31:0] rexp, input logic err,
                                 input logic mis, input int lat, input int alast);
        txn_t t;
        t.we = we; t.size = size; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.r = r; t.d = d; t.be = be; t.baddr = baddr; t.bwdata = bwdata;
        t.rdata_exp = rexp; t.err = err; t.mis = mis; t.lat = lat; t.addr_last = alast;
        return t;
    endfunction

    // Transaction-level reference: lane arithmetic plus a cycle budget.
    function automatic txn_t model(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int r, input int d, input logic [31:0] prev);
        txn_t        t;
        int          off;
        int          kt;
        logic [31:0] ext;
        off = int'(addr[1:0]);
        t.we = we; t.size = size; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.r = r; t.d = d; t.baddr = addr & 32'hFFFF_FFFC; t.err = 1'b0; t.mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        t.mis = (size == 2'd1 && addr[0]) || (size >= 2'd2 && off != 0);
`endif
        if (size == 2'd0) begin
            t.be     = 4'(1 << off);
            t.bwdata = {24'b0, wdata[7:0]} * 32'h0101_0101;
            ext      = (rdata >> (8 * off)) & 32'h0000_00FF;
        end else if (size == 2'd1) begin
            t.be     = 4'(3 << (off & 2));
            t.bwdata = {16'b0, wdata[15:0]} * 32'h0001_0001;
            ext      = (rdata >> (8 * (off & 2))) & 32'h0000_FFFF;
        end else begin
            t.be     = 4'hF;
            t.bwdata = wdata;
            ext      = rdata;
        end
        if (t.mis) begin
            t.lat = 1; t.addr_last = 0; t.rdata_exp = prev;
        end else if (r >= MAX_WAIT) begin
            t.lat = MAX_WAIT + 1; t.addr_last = MAX_WAIT; t.err = 1'b1; t.rdata_exp = '0;
        end else begin
            t.addr_last = r + 1;
            if (we || d == 0) begin
                t.lat = r + 2;
                t.rdata_exp = we ? prev : ext;
            end else begin
                kt = MAX_WAIT - r - 1;
                if (kt < 1) kt = 1;
                if (kt < d) begin
                    t.lat = r + kt + 2; t.err = 1'b1; t.rdata_exp = '0;
                end else begin
                    t.lat = r + d + 2; t.rdata_exp = ext;
                end
            end
        end
        return t;
    endfunction

    // Starts at a cycle where the DUT is idle; returns at the cycle after DONE
    // with req_valid still high so the caller may issue a back-to-back request.
    task automatic run_txn(input txn_t t, input string tag);
        logic exp_bv;
        req_valid = 1'b1;
        req_we    = t.we;
        req_size  = t.size;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        for (int c = 0; c <= t.lat; c++) begin
            bus_if.bus_ready  = (c >= 1) && (c - 1 == t.r);
            bus_if.bus_rvalid = !t.we && ((t.d == 0) ? (c == t.r + 1) : (c == t.r + 1 + t.d));
            bus_if.bus_rdata  = t.rdata;
            #1;
            exp_bv = !t.mis && (c >= 1) && (c <= t.addr_last);
            check({tag, " stall"}, stall, c != t.lat);
            check({tag, " rsp_valid"}, rsp_valid, c == t.lat);
            check({tag, " bus_valid"}, bus_if.bus_valid, exp_bv);
            if (exp_bv) begin
                check({tag, " bus_addr"}, bus_if.bus_addr, t.baddr);
                check({tag, " bus_be"}, bus_if.bus_be, t.be);
                check({tag, " bus_we"}, bus_if.bus_we, t.we);
                if (t.we) check({tag, " bus_wdata"}, bus_if.bus_wdata, t.bwdata);
            end
            if (c == t.lat) begin
                check({tag, " rsp_err"}, rsp_err, t.err);
                check({tag, " misalign"}, misalign, t.mis);
                check({tag, " rsp_rdata"}, rsp_rdata, t.rdata_exp);
            end else begin
                check({tag, " rdata_hold"}, rsp_rdata, model_rdata);
            end
            @(posedge clk);
            #1;
        end
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        model_rdata       = t.rdata_exp;
    endtask

    // Request low: the bus must stay quiet whatever else toggles.
    task automatic idle_cycle();
        req_valid         = 1'b0;
        req_we            = 1'($urandom);
        req_size          = 2'($urandom);
        req_addr          = $urandom;
        req_wdata         = $urandom;
        bus_if.bus_ready  = 1'($urandom);
        bus_if.bus_rvalid = 1'($urandom);
        bus_if.bus_rdata  = $urandom;
        #1;
        check("idle bus_valid", bus_if.bus_valid, 1'b0);
        check("idle stall", stall, 1'b0);
        check("idle rsp_valid", rsp_valid, 1'b0);
        check("idle rsp_rdata", rsp_rdata, model_rdata);
        @(posedge clk);
        #1;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " bus_valid"}, bus_if.bus_valid, 1'b0);
        check({tag, " rsp_valid"}, rsp_valid, 1'b0);
        check({tag, " rsp_err"}, rsp_err, 1'b0);
        check({tag, " misalign"}, misalign, 1'b0);
        check({tag, " bus_we"}, bus_if.bus_we, 1'b0);
        check({tag, " bus_be"}, bus_if.bus_be, 4'h0);
        check({tag, " bus_addr"}, bus_if.bus_addr, 32'h0);
        check({tag, " bus_wdata"}, bus_if.bus_wdata, 32'h0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    endtask

    txn_t tbl[12];
    txn_t t;
    int   rr;
    int   dd;

    initial begin
        rst               = 1'b1;
        req_valid         = 1'b0;
        req_we            = 1'b0;
        req_size          = 2'b00;
        req_addr          = '0;
        req_wdata         = '0;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;

        //            we size addr          wdata         rdata         r   d   be       baddr         bwdata        rdata_exp     err mis lat alast
        tbl[0]  = vec(1, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0,  0,  4'b1000, 32'h0000_1000, 32'hABAB_ABAB, 32'h0,        0, 0, 2,  1);
        tbl[1]  = vec(0, 1, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0,  0,  4'b1100, 32'h0000_2000, 32'h0,        32'h0000_BEEF, 0, 0, 2,  1);
        tbl[2]  = vec(0, 2, 32'h0000_0040, 32'h0,        32'h1234_5678, 20, 0,  4'b1111, 32'h0000_0040, 32'h0,        32'h0,        1, 0, 17, 16);
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[3]  = vec(1, 2, 32'h0000_0042, 32'hCAFE_F00D, 32'h0,        0,  0,  4'b1111, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        0, 1, 1,  0);
`else
        tbl[3]  = vec(1, 2, 32'h0000_0042, 32'hCAFE_F00D, 32'h0,        0,  0,  4'b1111, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        0, 0, 2,  1);
`endif
        tbl[4]  = vec(0, 0, 32'h0000_1001, 32'h0,        32'h1122_3344, 1,  2,  4'b0010, 32'h0000_1000, 32'h0,        32'h0000_0033, 0, 0, 5,  2);
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[5]  = vec(1, 1, 32'h0000_2003, 32'h1234_ABCD, 32'h0,        2,  0,  4'b1100, 32'h0000_2000, 32'hABCD_ABCD, 32'h0000_0033, 0, 1, 1,  0);
`else
        tbl[5]  = vec(1, 1, 32'h0000_2003, 32'h1234_ABCD, 32'h0,        2,  0,  4'b1100, 32'h0000_2000, 32'hABCD_ABCD, 32'h0000_0033, 0, 0, 4,  3);
`endif
        tbl[6]  = vec(1, 3, 32'h0000_3000, 32'h0102_0304, 32'h0,        0,  0,  4'b1111, 32'h0000_3000, 32'h0102_0304, 32'h0000_0033, 0, 0, 2,  1);
        tbl[7]  = vec(0, 1, 32'h0000_0010, 32'h0,        32'h7FFF_8001, 0,  1,  4'b0011, 32'h0000_0010, 32'h0,        32'h0000_8001, 0, 0, 3,  1);
        tbl[8]  = vec(0, 0, 32'h0000_0003, 32'h0,        32'hF0AB_CDEF, 0,  0,  4'b1000, 32'h0000_0000, 32'h0,        32'h0000_00F0, 0, 0, 2,  1);
        tbl[9]  = vec(0, 2, 32'h0000_0080, 32'h0,        32'h5555_AAAA, 2,  30, 4'b1111, 32'h0000_0080, 32'h0,        32'h0,        1, 0, 17, 3);
        tbl[10] = vec(1, 0, 32'h0000_0005, 32'h0000_005A, 32'h0,        15, 0,  4'b0010, 32'h0000_0004, 32'h5A5A_5A5A, 32'h0,        0, 0, 17, 16);
        tbl[11] = vec(1, 2, 32'h0000_0008, 32'h0000_0001, 32'h0,        16, 0,  4'b1111, 32'h0000_0008, 32'h0000_0001, 32'h0,        1, 0, 17, 16);

        #3;
        check_reset_values("reset");
        check("reset stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            idle_cycle();
        end

        // Back-to-back lb then sw with req_valid held through both.
        t = model(1'b0, 2'd0, 32'h0000_0502, 32'h0, 32'hA1B2_C3D4, 0, 0, model_rdata);
        run_txn(t, "b2b lb");
        t = model(1'b1, 2'd2, 32'h0000_0600, 32'h1357_9BDF, 32'h0, 0, 0, model_rdata);
        run_txn(t, "b2b sw");
        idle_cycle();

        // Randomized transactions, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            rr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
            t  = model(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, rr, dd, model_rdata);
            run_txn(t, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) != 0) begin
                for (int k = 0; k <= int'($urandom_range(0, 2)); k++) idle_cycle();
            end
        end
        idle_cycle();

        // Reset while waiting in RDATA; the late rvalid must be ignored.
        req_valid        = 1'b1;
        req_we           = 1'b0;
        req_size         = 2'd2;
        req_addr         = 32'h0000_0040;
        req_wdata        = '0;
        bus_if.bus_ready = 1'b0;
        @(posedge clk);
        #1;
        bus_if.bus_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_ready = 1'b0;
        #1;
        check("rdata-wait bus_valid", bus_if.bus_valid, 1'b0);
        check("rdata-wait stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_values("mid-reset");
        @(posedge clk);
        #1;
        rst         = 1'b0;
        req_valid   = 1'b0;
        model_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_rdata  = $urandom;
            #1;
            check("post-reset rsp_valid", rsp_valid, 1'b0);
            check("post-reset rsp_rdata", rsp_rdata, 32'h0);
            check("post-reset bus_valid", bus_if.bus_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        bus_if.bus_rvalid = 1'b0;
        t = model(1'b0, 2'd1, 32'h0000_0702, 32'h0, 32'h8765_4321, 1, 1, model_rdata);
        run_txn(t, "post-reset lh");
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 16: bus wait cycles before a timeout is declared.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  datapath memory access pending; held until the rsp_valid cycle.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 req_addr  in  32  byte address (datapath ALU result).
REQ-008 req_wdata  in  32  store data, right-justified.
REQ-009 stall  out  1  freezes the datapath PC and register write.
REQ-010 rsp_valid  out  1  one-cycle pulse: access complete.
REQ-011 rsp_rdata  out  32  load data, right-justified and zero-filled; the datapath load extender performs sign extension.
REQ-012 rsp_err  out  1  one-cycle pulse with rsp_valid on timeout.
REQ-013 misalign  out  1  one-cycle pulse with rsp_valid on a misaligned access (macro only; tied 0 otherwise).
REQ-014 bus_valid/bus_ready  out/in  1/1  address phase handshake.
REQ-015 bus_we  out  1  bus write enable.
REQ-016 bus_addr  out  32  word-aligned address, req_addr with bits [1:0] forced to 00.
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_be  out  4  byte-lane enables.
REQ-019 bus_rvalid/bus_rdata  in  1/32  read data return.

Function
REQ-020 FSM states: IDLE, ADDR, RDATA, DONE.
REQ-021 IDLE + req_valid -> ADDR: request fields and lane data are registered at this transition.
REQ-022 ADDR: bus_valid=1 and bus outputs stay stable until bus_ready=1.
REQ-023 ADDR + bus_ready on a store -> DONE.
REQ-024 ADDR + bus_ready on a load -> RDATA.
REQ-025 ADDR + bus_ready + bus_rvalid in the same cycle on a load: capture bus_rdata and go -> DONE.
REQ-026 RDATA: on bus_rvalid, capture the extracted data into rsp_rdata and go -> DONE.
REQ-027 DONE: rsp_valid=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-028 stall = req_valid AND state!=DONE (combinational), so the minimum stall is 2 cycles for a store and 2 cycles for a load with same-cycle rvalid.
REQ-029 Byte lanes:
- byte: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}
- half: be = 0011<<{addr[1],0}, wdata = {2{wdata[15:0]}}
- word: be = 1111, wdata unchanged.
REQ-030 Load extraction: byte = bus_rdata>>(8*addr[1:0]) masked to 8 bits; half = >>(16*addr[1]) masked to 16 bits; word unchanged.
REQ-031 A wait counter clears on entry to ADDR and counts each cycle spent in ADDR/RDATA.
REQ-032 Wait counter reaching MAX_WAIT: go -> DONE with rsp_err=1, rsp_rdata=0, bus_valid dropped.
REQ-033 rsp_rdata holds its value until the next load completes; a store does not change it.
REQ-034 req_valid low in IDLE: no bus activity.

Reset
REQ-035 rst (asynchronous) forces state=IDLE, wait counter=0, and bus_valid, rsp_valid, rsp_err, misalign, bus_we, bus_be, bus_addr, bus_wdata, rsp_rdata all 0.
REQ-036 Reset mid-transaction abandons the transaction with no response pulse; outstanding rvalid is ignored after reset.

Configuration
REQ-037 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, or word with addr[1:0]!=0, goes IDLE -> DONE with misalign=1, no bus_valid, rsp_rdata unchanged.
REQ-038 Macro LSU_MISALIGN_TRAP_EN undefined: the offending low address bits are ignored (half uses addr[1] only, word uses all lanes); misalign is tied 0.

Structure
REQ-039 Package lsu_pkg holds the state enum, size encodings (SZ_B, SZ_H, SZ_W) and the default MAX_WAIT.
REQ-040 Lane steering (be/wdata replication and read extraction) lives in combinational sub-module lsu_lane; the FSM and counter live in lsu_bus_ctrl.

Verification
REQ-041 sb addr=0x1003 wdata=0x000000AB, bus_ready immediately -> bus_addr=0x1000, be=1000, bus_wdata=0xABABABAB, rsp_valid 2 cycles after req.
REQ-042 lh addr=0x2002, bus_rdata=0xBEEF1234 with ready+rvalid same cycle -> rsp_rdata=0x0000BEEF.
REQ-043 lw addr=0x40, bus_ready held low 20 cycles, MAX_WAIT=16 -> rsp_err and rsp_valid pulse after 16 wait cycles, rsp_rdata=0.
REQ-044 sw addr=0x42 with LSU_MISALIGN_TRAP_EN -> misalign pulse, no bus_valid; without the macro -> be=1111, bus_addr=0x40.
REQ-045 rst asserted in RDATA, then rvalid arrives -> outputs at reset values, no rsp_valid.
REQ-046 Back-to-back lb then sw with req_valid held -> two separate rsp_valid pulses, an IDLE cycle between them, stall low only in the DONE cycles.
